// File: rtl/main_memory_responder.sv
// Memory-side responder for cache block fetch / write-back bursts over a valid/ready handshake.
// Holds a word-addressed backing store that keeps its contents across reset.
//
// state    | meaning
// IDLE     | ready for a request
// RD_WAIT  | counting read latency before the first read beat
// RD_BURST | streaming block_size read beats, one per cycle
// WR_BURST | accepting block_size write beats, gaps allowed
module main_memory_responder #(
  parameter int word_size    = 64,
  parameter int block_size   = 4,
  parameter int addr_width   = 32,
  parameter int mem_words    = 1024,
  parameter int read_latency = 2
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  req_valid,
  input  logic                  req_write,
  input  logic [addr_width-1:0] req_address,
  output logic                  req_ready,
  input  logic                  wr_valid,
  input  logic [word_size-1:0]  wr_data,
  output logic                  wr_ready,
  output logic                  rd_valid,
  output logic [word_size-1:0]  rd_data,
  output logic                  rd_last,
  output logic                  busy
);

  localparam int BB   = $clog2(block_size);
  localparam int MIDX = $clog2(mem_words);

  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] RD_WAIT  = 2'd1;
  localparam logic [1:0] RD_BURST = 2'd2;
  localparam logic [1:0] WR_BURST = 2'd3;

  logic [1:0]            state;
  logic [3:0]            lat_cnt;
  logic [3:0]            lat_nxt;
  logic [BB-1:0]         beat;
  logic                  last_beat;
  logic [addr_width-1:0] base;
  logic [addr_width-1:0] req_base;
  logic [MIDX-1:0]       idx;
  logic [word_size-1:0]  store [mem_words];

  assign req_base  = req_address & ~addr_width'(block_size - 1);
  // Out-of-range addresses wrap onto the store.
  assign idx       = MIDX'((base + addr_width'(beat)) % addr_width'(mem_words));
  assign last_beat = (beat == BB'(block_size - 1));
  assign lat_nxt   = lat_cnt + 4'd1;

  assign req_ready = (state == IDLE);
  assign busy      = !req_ready;
  assign wr_ready  = (state == WR_BURST);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      lat_cnt  <= '0;
      beat     <= '0;
      base     <= '0;
      rd_valid <= 1'b0;
      rd_last  <= 1'b0;
      rd_data  <= '0;
    end else begin
      case (state)
        IDLE: begin
          rd_valid <= 1'b0;
          rd_last  <= 1'b0;
          rd_data  <= '0;
          if (req_valid) begin
            base    <= req_base;
            beat    <= '0;
            lat_cnt <= '0;
            if (req_write)
              state <= WR_BURST;
            else if (read_latency > 0)
              state <= RD_WAIT;
            else
              state <= RD_BURST;
          end
        end
        RD_WAIT: begin
          lat_cnt <= lat_nxt;
          if (lat_nxt == 4'(read_latency))
            state <= RD_BURST;
        end
        RD_BURST: begin
          rd_valid <= 1'b1;
          rd_data  <= store[idx];
          rd_last  <= last_beat;
          beat     <= beat + BB'(1);
          // Leaving here while the last beat is on the bus lets the next request land one edge later.
          if (last_beat)
            state <= IDLE;
        end
        WR_BURST: begin
          if (wr_valid) begin
            beat <= beat + BB'(1);
            if (last_beat)
              state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // No reset: contents survive reset; an abort takes state to IDLE so no further beat is written.
  always_ff @(posedge clock) begin
    if (state == WR_BURST && wr_valid)
      store[idx] <= wr_data;
  end

endmodule

// File: tb/tb_main_memory_responder.sv
// Bench for main_memory_responder: two instances (read latency 2 and 0) checked every cycle
// against a transaction-level model, plus directed literal expectations.
module tb_main_memory_responder;

  logic        clock;
  logic        reset;
  logic        req_valid   [2];
  logic        req_write   [2];
  logic [31:0] req_address [2];
  logic        req_ready   [2];
  logic        wr_valid    [2];
  logic [63:0] wr_data     [2];
  logic        wr_ready    [2];
  logic        rd_valid    [2];
  logic [63:0] rd_data     [2];
  logic        rd_last     [2];
  logic        busy        [2];

  int checks   = 0;
  int failures = 0;

  main_memory_responder #(.read_latency(2)) u_lat2 (
    .clock(clock), .reset(reset),
    .req_valid(req_valid[0]), .req_write(req_write[0]), .req_address(req_address[0]),
    .req_ready(req_ready[0]), .wr_valid(wr_valid[0]), .wr_data(wr_data[0]),
    .wr_ready(wr_ready[0]), .rd_valid(rd_valid[0]), .rd_data(rd_data[0]),
    .rd_last(rd_last[0]), .busy(busy[0])
  );

  main_memory_responder #(.read_latency(0)) u_lat0 (
    .clock(clock), .reset(reset),
    .req_valid(req_valid[1]), .req_write(req_write[1]), .req_address(req_address[1]),
    .req_ready(req_ready[1]), .wr_valid(wr_valid[1]), .wr_data(wr_data[1]),
    .wr_ready(wr_ready[1]), .rd_valid(rd_valid[1]), .rd_data(rd_data[1]),
    .rd_last(rd_last[1]), .busy(busy[1])
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic int lat_of(input int i);
    return (i == 0) ? 2 : 0;
  endfunction

  // Transaction-level model: reads are scheduled by edges elapsed since acceptance.
  int          m_mode [2];
  int          m_t    [2];
  int          m_wcnt [2];
  logic [31:0] m_base [2];
  logic [63:0] m_store [2][1024];
  logic        e_rv [2];
  logic        e_rl [2];
  logic [63:0] e_rd [2];

  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 2; i++) begin
        m_mode[i] = 0;
        e_rv[i]   = 1'b0;
        e_rl[i]   = 1'b0;
        e_rd[i]   = 64'h0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        e_rv[i] = 1'b0;
        e_rl[i] = 1'b0;
        e_rd[i] = 64'h0;
        if (m_mode[i] == 0) begin
          if (req_valid[i]) begin
            m_base[i] = req_address[i] & ~32'h3;
            m_t[i]    = 0;
            m_wcnt[i] = 0;
            m_mode[i] = req_write[i] ? 2 : 1;
          end
        end else if (m_mode[i] == 1) begin
          m_t[i]++;
          if (m_t[i] > lat_of(i) && m_t[i] <= lat_of(i) + 4) begin
            int k;
            k       = m_t[i] - lat_of(i) - 1;
            e_rv[i] = 1'b1;
            e_rd[i] = m_store[i][(m_base[i] + 32'(k)) % 1024];
            e_rl[i] = (k == 3);
            if (k == 3) m_mode[i] = 0;
          end
        end else begin
          if (wr_valid[i]) begin
            m_store[i][(m_base[i] + 32'(m_wcnt[i])) % 1024] = wr_data[i];
            m_wcnt[i]++;
            if (m_wcnt[i] == 4) m_mode[i] = 0;
          end
        end
      end
    end
  end

  always @(negedge clock) begin
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("u%0d.req_ready", i), 64'(req_ready[i]), 64'(m_mode[i] == 0));
      chk($sformatf("u%0d.busy", i),      64'(busy[i]),      64'(m_mode[i] != 0));
      chk($sformatf("u%0d.wr_ready", i),  64'(wr_ready[i]),  64'(m_mode[i] == 2));
      chk($sformatf("u%0d.rd_valid", i),  64'(rd_valid[i]),  64'(e_rv[i]));
      chk($sformatf("u%0d.rd_last", i),   64'(rd_last[i]),   64'(e_rl[i]));
      chk($sformatf("u%0d.rd_data", i),   rd_data[i],        e_rd[i]);
    end
  end

  logic [63:0] got_d [8];
  int          got_e [8];
  logic        got_l [8];
  int          got_n;
  int          wr_cycles;
  logic        wr_after;

  // Returns at the falling edge following the acceptance edge (edge 0).
  task automatic issue(input int i, input bit wr, input logic [31:0] a);
    int n = 0;
    @(negedge clock);
    req_valid[i]   = 1'b1;
    req_write[i]   = wr;
    req_address[i] = a;
    while (!req_ready[i] && n < 50) begin
      @(negedge clock);
      n++;
    end
    if (n >= 50) chk("issue_timeout", 64'(n), 64'(0));
    @(posedge clock);
    @(negedge clock);
    req_valid[i] = 1'b0;
  endtask

  task automatic read_block(input int i, input logic [31:0] a, input bit poke);
    got_n = 0;
    issue(i, 1'b0, a);
    for (int e = 0; e < 12; e++) begin
      if (rd_valid[i]) begin
        if (got_n < 8) begin
          got_d[got_n] = rd_data[i];
          got_e[got_n] = e;
          got_l[got_n] = rd_last[i];
        end
        got_n++;
      end
      if (poke) begin
        if (e < 5) begin
          chk("busy_reject_ready", 64'(req_ready[i]), 64'(0));
          req_valid[i]   = 1'b1;
          req_write[i]   = 1'b0;
          req_address[i] = 32'h40;
        end else begin
          req_valid[i] = 1'b0;
        end
      end
      @(negedge clock);
    end
  endtask

  task automatic check_beats(input string name, input int lat,
                             input logic [63:0] d0, input logic [63:0] d1,
                             input logic [63:0] d2, input logic [63:0] d3);
    logic [63:0] d [4];
    d[0] = d0; d[1] = d1; d[2] = d2; d[3] = d3;
    chk({name, "_count"}, 64'(got_n), 64'(4));
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("%s_data%0d", name, k), got_d[k], d[k]);
      chk($sformatf("%s_edge%0d", name, k), 64'(got_e[k]), 64'(lat + 1 + k));
      chk($sformatf("%s_last%0d", name, k), 64'(got_l[k]), 64'(k == 3));
    end
  endtask

  task automatic write_block(input int i, input logic [31:0] a,
                             input logic [63:0] d0, input logic [63:0] d1,
                             input logic [63:0] d2, input logic [63:0] d3,
                             input logic [15:0] pat, input int plen);
    logic [63:0] d [4];
    int k = 0;
    d[0] = d0; d[1] = d1; d[2] = d2; d[3] = d3;
    wr_cycles = 0;
    issue(i, 1'b1, a);
    for (int s = 0; s < plen; s++) begin
      if (wr_ready[i]) wr_cycles++;
      wr_valid[i] = pat[s];
      wr_data[i]  = (pat[s] && k < 4) ? d[k] : 64'hDEAD;
      if (pat[s]) k++;
      @(negedge clock);
    end
    wr_valid[i] = 1'b0;
    wr_after    = wr_ready[i];
  endtask

  initial begin
    #300000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b0;
    for (int i = 0; i < 2; i++) begin
      req_valid[i] = 1'b0; req_write[i] = 1'b0; req_address[i] = 32'h0;
      wr_valid[i]  = 1'b0; wr_data[i]   = 64'h0;
    end
    repeat (3) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    chk("reset_req_ready", 64'(req_ready[0]), 64'(1));
    chk("reset_busy",      64'(busy[0]),      64'(0));
    chk("reset_rd_valid",  64'(rd_valid[0]),  64'(0));
    chk("reset_rd_data",   rd_data[0],        64'h0);
    chk("reset_wr_ready",  64'(wr_ready[0]),  64'(0));

    write_block(0, 32'h10, 64'hA0, 64'hA1, 64'hA2, 64'hA3, 16'b1111, 4);
    read_block(0, 32'h13, 1'b0);
    check_beats("rd_0x13", 2, 64'hA0, 64'hA1, 64'hA2, 64'hA3);

    write_block(0, 32'h20, 64'hB0, 64'hB1, 64'hB2, 64'hB3, 16'b1011001, 7);
    chk("gap_wr_ready_cycles", 64'(wr_cycles), 64'(7));
    chk("gap_wr_ready_after",  64'(wr_after),  64'(0));
    // Stray write beats while idle must not land in the store.
    wr_valid[0] = 1'b1;
    wr_data[0]  = 64'hEE;
    repeat (3) @(negedge clock);
    wr_valid[0] = 1'b0;
    read_block(0, 32'h20, 1'b0);
    check_beats("rd_0x20", 2, 64'hB0, 64'hB1, 64'hB2, 64'hB3);

    read_block(0, 32'h13, 1'b1);
    check_beats("rd_busy", 2, 64'hA0, 64'hA1, 64'hA2, 64'hA3);
    read_block(0, 32'h410, 1'b0);
    check_beats("rd_alias", 2, 64'hA0, 64'hA1, 64'hA2, 64'hA3);

    write_block(1, 32'h10, 64'hA0, 64'hA1, 64'hA2, 64'hA3, 16'b1111, 4);
    got_n = 0;
    issue(1, 1'b0, 32'h10);
    req_valid[1]   = 1'b1;
    req_address[1] = 32'h10;
    for (int e = 0; e < 12; e++) begin
      if (rd_valid[1]) begin
        if (got_n < 8) begin
          got_d[got_n] = rd_data[1];
          got_e[got_n] = e;
          got_l[got_n] = rd_last[1];
        end
        got_n++;
      end
      if (e == 3) chk("lat0_ready_e3", 64'(req_ready[1]), 64'(0));
      if (e == 4) chk("lat0_ready_e4", 64'(req_ready[1]), 64'(1));
      if (e == 5) begin
        chk("lat0_ready_e5", 64'(req_ready[1]), 64'(0));
        req_valid[1] = 1'b0;
      end
      @(negedge clock);
    end
    chk("lat0_count", 64'(got_n), 64'(8));
    chk("lat0_first_edge",  64'(got_e[0]), 64'(1));
    chk("lat0_last_edge",   64'(got_e[3]), 64'(4));
    chk("lat0_last_flag",   64'(got_l[3]), 64'(1));
    chk("lat0_b2b_edge",    64'(got_e[4]), 64'(6));
    chk("lat0_b2b_data",    got_d[4],      64'hA0);
    chk("lat0_b2b_last",    64'(got_l[7]), 64'(1));

    write_block(0, 32'h30, 64'hD0, 64'hD1, 64'hD2, 64'hD3, 16'b1111, 4);
    issue(0, 1'b1, 32'h30);
    wr_valid[0] = 1'b1;
    wr_data[0]  = 64'hC0;
    @(negedge clock);
    wr_data[0]  = 64'hC1;
    @(negedge clock);
    wr_data[0]  = 64'hC2;
    #2 reset = 1'b0;
    #1;
    chk("abort_req_ready", 64'(req_ready[0]), 64'(1));
    chk("abort_busy",      64'(busy[0]),      64'(0));
    chk("abort_wr_ready",  64'(wr_ready[0]),  64'(0));
    chk("abort_rd_valid",  64'(rd_valid[0]),  64'(0));
    wr_valid[0] = 1'b0;
    repeat (2) @(negedge clock);
    reset = 1'b1;
    read_block(0, 32'h30, 1'b0);
    check_beats("rd_abort", 2, 64'hC0, 64'hC1, 64'hD2, 64'hD3);

    repeat (2) @(negedge clock);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
